// File: rtl/jt49_bus_pkg.sv
// ---------------------------------------------------------------------------
// jt49_bus_pkg
// Shared definitions for the AY-3-8910 BDIR/BC1 bus master:
//   - FSM state encoding (IDLE, ADDR, GAP1, XFER, GAP2, DONE)
//   - 2-bit bus phase codes driven on {bdir,bc1}
//   - phase counter width
//   - bus_phase(): maps an FSM state (plus direction) to its pin phase
// ---------------------------------------------------------------------------
package jt49_bus_pkg;

   // Phase counter width; HOLD and GAP must fit as (value-1).
   localparam int CNT_W = 4;

   // {bdir,bc1} pin phases
   localparam logic [1:0] PH_INACT = 2'b00;
   localparam logic [1:0] PH_READ  = 2'b01;
   localparam logic [1:0] PH_WRITE = 2'b10;
   localparam logic [1:0] PH_LATCH = 2'b11;

   // FSM state encoding, kept as plain constants for legacy tool flows
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_ADDR = 3'd1;
   localparam state_t ST_GAP1 = 3'd2;
   localparam state_t ST_XFER = 3'd3;
   localparam state_t ST_GAP2 = 3'd4;
   localparam state_t ST_DONE = 3'd5;

   // Pin phase presented while the FSM sits in a given state.
   function automatic logic [1:0] bus_phase(input state_t st, input logic we);
      case (st)
         ST_ADDR: bus_phase = PH_LATCH;
         ST_XFER: bus_phase = we ? PH_WRITE : PH_READ;
         default: bus_phase = PH_INACT;
      endcase
   endfunction

endpackage

// File: rtl/jt49_bus_phase_timer.sv
// ---------------------------------------------------------------------------
// jt49_bus_phase_timer
// Loadable down-counter shared by every bus phase. A phase is entered with
// load=1 and load_val=(length-1); the phase ends on the cycle zero=1.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   load     in  load load_val on the next edge (overrides counting)
//   load_val in  CNT_W-bit reload value
//   value    out current count
//   zero     out count is 0 (last cycle of the current phase)
// ---------------------------------------------------------------------------
module jt49_bus_phase_timer
   import jt49_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates at 0 so an idle FSM leaves the counter parked.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/jt49_bus_master.sv
// ---------------------------------------------------------------------------
// jt49_bus_master
// Initiator for the AY-3-8910 BDIR/BC1 bus. A single-cycle host request
// (req & ready) is turned into: address latch (11), gap (00), write (10) or
// read (01) phase, gap (00), then a one-cycle ack. All pin outputs are
// registered and decoded from the next state, so they change together with
// the FSM and nothing from req reaches the pins combinationally.
//
// Parameters:
//   HOLD    cycles per active phase (2..15)
//   GAP     inactive cycles after each active phase (1..15)
//   ADDR_HI chip-select nibble placed on bus_dout[7:4] while latching
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req, we, addr, wdata host request; fields sampled on accept
//   ready, ack, rdata   idle flag, end-of-sequence pulse, read result
//   bdir, bc1           PSG bus control pins
//   bus_dout, bus_oe    data/address to target and its output enable
//   bus_din             data from target
//
// Build option:
//   JT49_ADDR_CACHE_EN  remember the last latched address; a request to the
//                       same address skips ADDR and GAP1. Only reset
//                       invalidates the cached address.
// ---------------------------------------------------------------------------
module jt49_bus_master
   import jt49_bus_pkg::*;
#(
   parameter int unsigned HOLD    = 2,
   parameter int unsigned GAP     = 1,
   parameter logic [3:0]  ADDR_HI = 4'h0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       we,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   output logic       ready,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       bdir,
   output logic       bc1,
   output logic [7:0] bus_dout,
   output logic       bus_oe,
   input  logic [7:0] bus_din
);

   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

   state_t           state_q, state_d;
   logic             we_q, we_d;
   logic [3:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             ack_q, ack_d;
   logic [1:0]       ph_q, ph_d;
   logic [7:0]       dout_q, dout_d;
   logic             oe_q, oe_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_zero;

`ifdef JT49_ADDR_CACHE_EN
   logic             cvalid_q, cvalid_d;
`endif

   jt49_bus_phase_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      tmr_load     = 1'b0;
      tmr_load_val = HOLD_LD;
`ifdef JT49_ADDR_CACHE_EN
      cvalid_d     = cvalid_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // ready is asserted exactly while in IDLE
            if (req) begin
               we_d         = we;
               addr_d       = addr;
               wdata_d      = wdata;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LD;
`ifdef JT49_ADDR_CACHE_EN
               // Target still holds this register number: go straight to data.
               cvalid_d     = 1'b1;
               state_d      = (cvalid_q && (addr == addr_q)) ? ST_XFER : ST_ADDR;
`else
               state_d      = ST_ADDR;
`endif
            end
         end
         ST_ADDR: begin
            if (tmr_zero) begin
               state_d      = ST_GAP1;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LD;
            end
         end
         ST_GAP1: begin
            if (tmr_zero) begin
               state_d      = ST_XFER;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LD;
            end
         end
         ST_XFER: begin
            // Sample the target as late as possible in the read phase.
            if (!we_q && (tmr_value == '0)) begin
               rdata_d = bus_din;
            end
            if (tmr_zero) begin
               state_d      = ST_GAP2;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LD;
            end
         end
         ST_GAP2: begin
            if (tmr_zero) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are registered
      // alongside it rather than lagging by a cycle.
      ph_d    = bus_phase(state_d, we_d);
      oe_d    = (state_d == ST_ADDR) || ((state_d == ST_XFER) && we_d);
      dout_d  = '0;
      if (state_d == ST_ADDR) begin
         dout_d = {ADDR_HI, addr_d};
      end else if ((state_d == ST_XFER) && we_d) begin
         dout_d = wdata_d;
      end
      ready_d = (state_d == ST_IDLE);
      ack_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         ack_q   <= 1'b0;
         ph_q    <= PH_INACT;
         dout_q  <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         ph_q    <= ph_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
      end
   end

`ifdef JT49_ADDR_CACHE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cvalid_q <= 1'b0;
      end else begin
         cvalid_q <= cvalid_d;
      end
   end
`endif

   assign ready    = ready_q;
   assign ack      = ack_q;
   assign rdata    = rdata_q;
   assign bdir     = ph_q[1];
   assign bc1      = ph_q[0];
   assign bus_dout = dout_q;
   assign bus_oe   = oe_q;

endmodule

// File: doc/jt49_bus_master.md
# jt49_bus_master

Initiator side of the AY-3-8910 BDIR/BC1 bus. Converts single-cycle host register requests (write or read of PSG register 0–15) into the chip's bus sequence: latch-address, inactive gap, write or read phase, inactive gap. Sits between a CPU/host core and a `jt49_bus`-style target, or drives real PSG pins through the FPGA I/O. Produces `ack` with read data when the sequence completes.

## Interface
- `HOLD`, 2: clock cycles each active phase (address, write, read) is held; legal range 2–15.
- `GAP`, 1: inactive (`bdir,bc1`=00) cycles after each active phase; legal range 1–15.
- `ADDR_HI`, 4'h0: value driven on `bus_dout[7:4]` during the address phase (chip-select nibble).

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: host request; accepted when `req & ready`.
- `we` in 1: 1 = write, 0 = read; sampled on accept.
- `addr` in 4: register number; sampled on accept.
- `wdata` in 8: write data; sampled on accept.
- `ready` out 1: idle, can accept a request.
- `ack` out 1: one-cycle pulse at sequence end.
- `rdata` out 8: read result; valid with `ack` on reads, held until next read completes.
- `bdir` out 1: bus direction pin.
- `bc1` out 1: bus control pin.
- `bus_dout` out 8: data/address driven to target.
- `bus_oe` out 1: `bus_dout` output enable.
- `bus_din` in 8: data from target.

## Operation
- States: IDLE, ADDR, GAP1, XFER, GAP2, DONE.
- IDLE: `ready`=1, `bdir,bc1`=00. On accept, latch `we/addr/wdata`, go ADDR.
- ADDR: `bdir,bc1`=11, `bus_dout`={ADDR_HI,addr}, `bus_oe`=1, for HOLD cycles -> GAP1.
- GAP1: 00, `bus_oe`=0, GAP cycles -> XFER.
- XFER write: 10, `bus_dout`=wdata, `bus_oe`=1, HOLD cycles. XFER read: 01, `bus_oe`=0; `bus_din` captured into `rdata` on the last XFER cycle. -> GAP2.
- GAP2: 00, GAP cycles -> DONE.
- DONE: `ack`=1 for one cycle, -> IDLE (`ready` returns next cycle).
- `req` while not ready is ignored; no queueing. `req` held high across DONE is accepted as a new request on the first IDLE cycle.
- Phase counter is 4 bits, loaded with HOLD-1 or GAP-1, counts to 0; transitions occur on the cycle the counter reads 0.
- Reset (any time, including mid-sequence): all outputs go to reset values immediately: `bdir,bc1`=00, `bus_oe`=0, `bus_dout`=0, `ready`=1 after release, `ack`=0, `rdata`=0, state IDLE, address cache invalid.

## Timing
- Write latency accept->ack: 1 + HOLD + GAP + HOLD + GAP cycles (defaults: 7); the accept cycle counts as 1.
- Read identical; `rdata` updates on the cycle before `ack`.
- HOLD ≥ 2 is required because the target registers `cs_n/wr_n` one cycle after sampling `bdir,bc1`.
- Outputs are registered; no combinational path from `req` to bus pins.

## Configuration
- `JT49_ADDR_CACHE_EN` defined: the block remembers the last latched address; if a new request has the same `addr` and the cache is valid, ADDR and GAP1 are skipped (IDLE -> XFER). Latency drops by HOLD+GAP. Cache is invalidated by reset only.
- Not defined: every request performs the full address phase.

## Structure
- `jt49_bus_pkg`: state enum, 2-bit phase constants (INACT=00, READ=01, WRITE=10, LATCH=11), counter width.
- Sub-module `jt49_bus_phase_timer`: loadable 4-bit down-counter with `load`, `value`, `zero` outputs, shared by all phases.

## Test plan
- Write addr=7 data=8'h38, defaults -> bus shows 11/{0,7} 2 cycles, 00 1 cycle, 10/38 2 cycles, 00 1 cycle; `ack` 7 cycles after accept; attached target register 7 = 8'h38.
- Read addr=0 after writing 8'hA5 -> `bdir,bc1`=01 for 2 cycles, `rdata`=8'hA5 with `ack`.
- `req` pulsed during XFER -> ignored, no second `ack`; back-to-back `req` held high -> two sequences, one idle cycle between.
- Assert `rst_n`=0 during write XFER -> `bdir,bc1`=00, `bus_oe`=0 in same cycle; target register unchanged; after release, `ready`=1.
- ADDR_HI=4'h1 -> target rejects address, write has no effect, `ack` still produced.
- With `JT49_ADDR_CACHE_EN`: two writes to addr=3 -> second shows no 11 phase, latency 4; write to addr=4 restores full sequence.
